// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage_if
//  Description : Bundle of the fetch stage's memory, decode and redirect
//                signals. The master side is the fetch stage itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface if_fetch_stage_if;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] PC;
    logic [31:0] if_Inst;
    logic        if_valid;

    modport master (
        output imem_en, imem_addr, PC, if_Inst, if_valid,
        input  imem_rdata, id_stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, PC, if_Inst, if_valid,
        output imem_rdata, id_stall, redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage
//  Description : Instruction fetch stage. Owns the fetch PC, issues reads to
//                a one-cycle-latency instruction memory and buffers returned
//                words in a 2-entry skid FIFO so decode may stall freely.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              Clock,
    input  logic              Resetn,
    if_fetch_stage_if.master  bus
);

    logic [31:0] r_fetch_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic [31:0] r_fifo_pc   [0:1];
    logic [31:0] r_fifo_inst [0:1];
    logic [1:0]  r_count;
    logic        r_head;
    logic        r_tail;

    logic        w_valid;
    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic [2:0]  w_occupancy;

    // Handshake, credit and output decode. A pop frees a slot in the same
    // cycle, which is what lets a new read issue at the stall-release edge
    // and keeps the resume bubble-free.
    always_comb begin
        w_valid     = (r_count != 2'd0);
        w_pop       = w_valid & ~bus.id_stall & ~bus.redirect;
        w_push      = r_inflight & ~bus.redirect;
        w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue     = Resetn & ~bus.redirect & (w_occupancy < 3'd2);

        bus.imem_en   = w_issue;
        bus.imem_addr = r_fetch_pc;
        bus.PC        = r_fifo_pc[r_head];
        bus.if_Inst   = r_fifo_inst[r_head];
        bus.if_valid  = w_valid;
    end

    // Fetch PC, in-flight tracking and FIFO state; reset beats redirect,
    // redirect beats push, pop and issue.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_fetch_pc     <= RESET_PC;
            r_inflight     <= 1'b0;
            r_inflight_pc  <= 32'h0;
            r_count        <= 2'd0;
            r_head         <= 1'b0;
            r_tail         <= 1'b0;
            r_fifo_pc[0]   <= 32'h0;
            r_fifo_pc[1]   <= 32'h0;
            r_fifo_inst[0] <= 32'h0;
            r_fifo_inst[1] <= 32'h0;
        end else if (bus.redirect) begin
            r_fetch_pc <= bus.redirect_pc;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end else begin
                r_inflight    <= 1'b0;
            end

            if (w_push) begin
                r_fifo_pc[r_tail]   <= r_inflight_pc;
                r_fifo_inst[r_tail] <= bus.imem_rdata;
                r_tail              <= ~r_tail;
            end

            if (w_pop) begin
                r_head <= ~r_head;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire
